// File: rtl/sar_conv_sequencer.sv
// Conversion sequencer for the EEG front-end SAR ADC: sample phase, N-bit search
// with core enable gating, result capture and a valid/ready result port.
module sar_conv_sequencer #(
  parameter int N_BITS        = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic              abort,
  output logic              sample,
  output logic              sar_en,
  input  logic [N_BITS-1:0] sar_d,
  output logic              busy,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic [N_BITS-1:0] result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              done,
  output logic              overrun
);

  localparam int SCNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [SCNT_W-1:0] SAMPLE_LAST = SCNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST    = CNT_W'(N_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONVERT, S_CAPTURE} state_t;

  state_t              state;
  logic [SCNT_W-1:0]   scnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      scnt         <= '0;
      sample       <= 1'b0;
      sar_en       <= 1'b0;
      busy         <= 1'b0;
      bit_cnt      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      done <= 1'b0;
      // A consume can be overridden below by a capture on the same edge.
      if (result_valid && result_ready)
        result_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_SAMPLE;
            scnt   <= '0;
            sample <= 1'b1;
            busy   <= 1'b1;
          end
        end

        S_SAMPLE: begin
          if (abort) begin
            state  <= S_IDLE;
            sample <= 1'b0;
            busy   <= 1'b0;
          end else if (scnt == SAMPLE_LAST) begin
            state   <= S_CONVERT;
            sample  <= 1'b0;
            sar_en  <= 1'b1;
            bit_cnt <= '0;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end

        S_CONVERT: begin
          if (abort) begin
            state   <= S_IDLE;
            sar_en  <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= '0;
          end else if (bit_cnt == BIT_LAST) begin
            state   <= S_CAPTURE;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        S_CAPTURE: begin
          if (abort) begin
            state  <= S_IDLE;
            sar_en <= 1'b0;
            busy   <= 1'b0;
          end else begin
            result       <= sar_d;
            result_valid <= 1'b1;
            done         <= 1'b1;
            overrun      <= overrun | (result_valid & ~result_ready);
            // Dropping sar_en here clears the core for the next sample.
            sar_en       <= 1'b0;
            if (cont || start) begin
              state  <= S_SAMPLE;
              scnt   <= '0;
              sample <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state   <= S_IDLE;
          sample  <= 1'b0;
          sar_en  <= 1'b0;
          busy    <= 1'b0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule
